adc_drdy_gen: RTL and testbench

Synthesizable ADC-side DRDY generator: the transmitting end of the active-low DRDY pacing interface used by ADS131M08-like ADCs.
- Produces adc_drdy_n frames at a programmable conversion period.
- Holds DRDY low until the host starts a read; flags frames that are overrun.
- Used for on-chip loopback/self-test of the DRDY receive path and as a bench stimulus source. All logic is in the clk domain; adc_drdy_n is driven directly from a flop (glitch-free).

---
 rtl/adc_drdy_gen_if.sv | 36 +++
 rtl/adc_drdy_gen.sv | 141 ++++++++++++++
 tb/tb_adc_drdy_gen.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_drdy_gen_if.sv
// adc_drdy_gen_if: host <-> ADC-side DRDY generator signal bundle.
// ADC_DRDY_GEN_OVR_IRQ_EN adds the overrun interrupt pair.
interface adc_drdy_gen_if #(
    parameter int PERIOD_W = 16,
    parameter int SEQ_W    = 8
);
    logic                enable;
    logic [PERIOD_W-1:0] period;
    logic                read_start;
    logic                adc_drdy_n;
    logic [SEQ_W-1:0]    frame_seq;
    logic [7:0]          missed_cnt;
    logic                busy;
`ifdef ADC_DRDY_GEN_OVR_IRQ_EN
    logic                ovr_clr;
    logic                ovr_irq;

    modport master (
        output enable, period, read_start, ovr_clr,
        input  adc_drdy_n, frame_seq, missed_cnt, busy, ovr_irq
    );
    modport slave (
        input  enable, period, read_start, ovr_clr,
        output adc_drdy_n, frame_seq, missed_cnt, busy, ovr_irq
    );
`else
    modport master (
        output enable, period, read_start,
        input  adc_drdy_n, frame_seq, missed_cnt, busy
    );
    modport slave (
        input  enable, period, read_start,
        output adc_drdy_n, frame_seq, missed_cnt, busy
    );
`endif
endinterface

// File: rtl/adc_drdy_gen.sv
// adc_drdy_gen: ADC-side active-low DRDY frame generator with overrun count.
// Optional macro ADC_DRDY_GEN_OVR_IRQ_EN adds a sticky overrun interrupt.
module adc_drdy_gen #(
    parameter int PERIOD_W = 16,
    parameter int GAP_CYC  = 2,
    parameter int SEQ_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    adc_drdy_gen_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY, S_GAP} state_t;

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(GAP_CYC + 2);
    localparam logic [3:0]          GAP_L = 4'(GAP_CYC);

    state_t              state;
    state_t              state_nx;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] period_eff;
    logic [3:0]          gap_cnt;
    logic [SEQ_W-1:0]    seq_q;
    logic [7:0]          missed_q;
    logic                drdy_n_q;
    logic                tick;
    logic                gap_done;
    logic                present;
    logic                miss;
    logic                busy_c;

    assign period_eff = (bus.period < MIN_P) ? MIN_P : bus.period;
    assign tick       = (state != S_IDLE) &&
                        (cnt == period_q - PERIOD_W'(1));
    assign gap_done   = (state == S_GAP) && (gap_cnt == 4'd1);

    // State register; DRDY comes straight off a flop fed by next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            drdy_n_q <= 1'b1;
        end else begin
            state    <= state_nx;
            drdy_n_q <= (state_nx != S_READY);
        end
    end

    // Next-state and frame/miss event decode
    always_comb begin
        state_nx = state;
        present  = 1'b0;
        miss     = 1'b0;
        if (!bus.enable) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: state_nx = S_WAIT;
                S_WAIT: begin
                    if (tick) begin
                        state_nx = S_READY;
                        present  = 1'b1;
                    end
                end
                S_READY: begin
                    if (tick) begin
                        state_nx = S_GAP;
                        miss     = !bus.read_start;
                    end else if (bus.read_start) begin
                        state_nx = S_WAIT;
                    end
                end
                S_GAP: begin
                    if (gap_done) begin
                        state_nx = S_READY;
                        present  = 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy_c = (state != S_IDLE);
    end

    // Conversion counter, latched period and gap countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            period_q <= '0;
            gap_cnt  <= '0;
        end else begin
            if (!bus.enable || state == S_IDLE || tick)
                cnt <= '0;
            else
                cnt <= cnt + PERIOD_W'(1);
            if (bus.enable && (state == S_IDLE || tick))
                period_q <= period_eff;
            if (bus.enable && state == S_READY && tick)
                gap_cnt <= GAP_L;
            else if (state == S_GAP && gap_cnt != 4'd0)
                gap_cnt <= gap_cnt - 4'd1;
        end
    end

    // Frame sequence (wrapping) and missed-frame count (saturating)
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q    <= '0;
            missed_q <= '0;
        end else begin
            if (present)
                seq_q <= seq_q + SEQ_W'(1);
            if (miss && missed_q != 8'hFF)
                missed_q <= missed_q + 8'd1;
        end
    end

`ifdef ADC_DRDY_GEN_OVR_IRQ_EN
    logic ovr_q;

    // Sticky overrun flag; a new miss beats a coincident clear
    always_ff @(posedge clk) begin
        if (rst)
            ovr_q <= 1'b0;
        else if (miss)
            ovr_q <= 1'b1;
        else if (bus.ovr_clr)
            ovr_q <= 1'b0;
    end

    assign bus.ovr_irq = ovr_q;
`endif

    assign bus.adc_drdy_n = drdy_n_q;
    assign bus.frame_seq  = seq_q;
    assign bus.missed_cnt = missed_q;
    assign bus.busy       = busy_c;
endmodule

// File: tb/tb_adc_drdy_gen.sv
// tb_adc_drdy_gen: scoreboard bench for adc_drdy_gen.
// Expectations are queued against edge numbers and checked as edges pass.
module tb_adc_drdy_gen;
    localparam int K_DRDY = 0;
    localparam int K_SEQ  = 1;
    localparam int K_MISS = 2;
    localparam int K_BUSY = 3;
    localparam int K_OVR  = 4;

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string tag;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];

    adc_drdy_gen_if bus ();

    adc_drdy_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d, want %0d",
                     tag, cyc, obs, exp);
        end
    endtask

    function automatic int obs_of(input int k);
        case (k)
            K_DRDY:  return int'(bus.adc_drdy_n);
            K_SEQ:   return int'(bus.frame_seq);
            K_MISS:  return int'(bus.missed_cnt);
            K_BUSY:  return int'(bus.busy);
`ifdef ADC_DRDY_GEN_OVR_IRQ_EN
            K_OVR:   return int'(bus.ovr_irq);
`endif
            default: return -1;
        endcase
    endfunction

    task automatic expect_at(input int c, input int k,
                             input int v, input string t);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        e.tag  = t;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check($sformatf("%s@%0d", e.tag, e.cyc), obs_of(e.kind), e.val);
        end
    endtask

    task automatic flush_sb();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s@%0d: never reached, want %0d",
                     e.tag, e.cyc, e.val);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.period     = '0;
        bus.read_start = 1'b0;
`ifdef ADC_DRDY_GEN_OVR_IRQ_EN
        bus.ovr_clr    = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = -1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = -1;

        // Reset state
        do_reset();
        check("rst_drdy", int'(bus.adc_drdy_n), 1);
        check("rst_seq",  int'(bus.frame_seq),  0);
        check("rst_miss", int'(bus.missed_cnt), 0);
        check("rst_busy", int'(bus.busy),       0);

        // Periodic frames, each read 3 cycles after its fall
        do_reset();
        bus.period = 16'd10;
        bus.enable = 1'b1;
        expect_at(0,  K_BUSY, 1, "t1_busy");
        expect_at(9,  K_DRDY, 1, "t1_drdy");
        expect_at(10, K_DRDY, 0, "t1_drdy");
        expect_at(12, K_DRDY, 0, "t1_drdy");
        expect_at(13, K_DRDY, 1, "t1_drdy");
        expect_at(19, K_DRDY, 1, "t1_drdy");
        expect_at(20, K_DRDY, 0, "t1_drdy");
        expect_at(23, K_DRDY, 1, "t1_drdy");
        expect_at(30, K_DRDY, 0, "t1_drdy");
        expect_at(33, K_DRDY, 1, "t1_drdy");
        expect_at(33, K_SEQ,  3, "t1_seq");
        expect_at(33, K_MISS, 0, "t1_miss");
        while (cyc < 35) begin
            bus.read_start = ((cyc + 1) % 10 == 3) && (cyc + 1 > 10);
            step();
        end
        bus.read_start = 1'b0;
        flush_sb();

        // Unread frames: gap, miss counting, saturation, seq wrap
        do_reset();
        bus.period = 16'd10;
        bus.enable = 1'b1;
        expect_at(10,   K_DRDY, 0,   "t2_drdy");
        expect_at(19,   K_DRDY, 0,   "t2_drdy");
        expect_at(20,   K_DRDY, 1,   "t2_gap");
        expect_at(21,   K_DRDY, 1,   "t2_gap");
        expect_at(22,   K_DRDY, 0,   "t2_drdy");
        expect_at(22,   K_SEQ,  2,   "t2_seq");
        expect_at(22,   K_MISS, 1,   "t2_miss");
        expect_at(2550, K_MISS, 254, "t2_miss");
        expect_at(2560, K_MISS, 255, "t2_sat");
        expect_at(3025, K_MISS, 255, "t2_sat");
        expect_at(3025, K_SEQ,  46,  "t2_wrap");
        while (cyc < 3025) step();
        flush_sb();

        // Period below minimum is clamped to GAP_CYC+2
        do_reset();
        bus.period = 16'd1;
        bus.enable = 1'b1;
        for (int c = 3; c <= 40; c++) begin
            if (c < 4)
                expect_at(c, K_DRDY, 1, "t3_drdy");
            else if (c < 8)
                expect_at(c, K_DRDY, 0, "t3_drdy");
            else
                expect_at(c, K_DRDY, ((c - 8) % 4 < 2) ? 1 : 0, "t3_drdy");
        end
        expect_at(4,  K_SEQ, 1, "t3_seq");
        expect_at(9,  K_SEQ, 1, "t3_seq");
        expect_at(10, K_SEQ, 2, "t3_seq");
        expect_at(13, K_SEQ, 2, "t3_seq");
        expect_at(14, K_SEQ, 3, "t3_seq");
        expect_at(38, K_SEQ, 9, "t3_seq");
        expect_at(7,  K_MISS, 0, "t3_miss");
        expect_at(8,  K_MISS, 1, "t3_miss");
        expect_at(40, K_MISS, 9, "t3_miss");
        while (cyc < 40) step();
        flush_sb();

        // Read coincident with tick; reads in WAIT and GAP ignored
        do_reset();
        bus.period = 16'd10;
        bus.enable = 1'b1;
        expect_at(5,  K_DRDY, 1, "t4_wait_rd");
        expect_at(10, K_DRDY, 0, "t4_drdy");
        expect_at(10, K_SEQ,  1, "t4_seq");
        expect_at(20, K_DRDY, 1, "t4_gap");
        expect_at(21, K_DRDY, 1, "t4_gap_rd");
        expect_at(22, K_DRDY, 0, "t4_drdy");
        expect_at(22, K_MISS, 0, "t4_miss");
        expect_at(22, K_SEQ,  2, "t4_seq");
        expect_at(25, K_DRDY, 1, "t4_read");
        expect_at(30, K_DRDY, 0, "t4_drdy");
        expect_at(30, K_SEQ,  3, "t4_seq");
        expect_at(30, K_MISS, 0, "t4_miss");
        while (cyc < 31) begin
            bus.read_start = (cyc + 1 == 5) || (cyc + 1 == 20) ||
                             (cyc + 1 == 21) || (cyc + 1 == 25);
            step();
        end
        bus.read_start = 1'b0;
        flush_sb();

        // Enable drop in READY, re-enable, reset mid-GAP
        do_reset();
        bus.period = 16'd10;
        bus.enable = 1'b1;
        expect_at(23, K_DRDY, 0, "t5_drdy");
        expect_at(24, K_DRDY, 1, "t5_off");
        expect_at(24, K_BUSY, 0, "t5_busy");
        expect_at(34, K_SEQ,  2, "t5_hold");
        expect_at(34, K_MISS, 1, "t5_hold");
        expect_at(35, K_BUSY, 1, "t5_busy");
        expect_at(40, K_DRDY, 1, "t5_drdy");
        expect_at(41, K_DRDY, 0, "t5_fall");
        expect_at(41, K_SEQ,  3, "t5_seq");
        expect_at(47, K_DRDY, 1, "t5_gap");
        expect_at(48, K_DRDY, 1, "t5_rst");
        expect_at(48, K_BUSY, 0, "t5_rst");
        expect_at(48, K_SEQ,  0, "t5_rst");
        expect_at(48, K_MISS, 0, "t5_rst");
        expect_at(49, K_BUSY, 1, "t5_busy");
        expect_at(55, K_DRDY, 1, "t5_drdy");
        expect_at(56, K_DRDY, 0, "t5_fall");
        expect_at(56, K_SEQ,  1, "t5_seq");
        while (cyc < 57) begin
            if (cyc + 1 == 24) bus.enable = 1'b0;
            if (cyc + 1 == 35) begin
                bus.enable = 1'b1;
                bus.period = 16'd6;
            end
            if (cyc + 1 == 48) rst = 1'b1;
            if (cyc + 1 == 49) begin
                rst        = 1'b0;
                bus.period = 16'd7;
            end
            step();
        end
        flush_sb();

`ifdef ADC_DRDY_GEN_OVR_IRQ_EN
        // Overrun interrupt: set, clear, set beats clear
        do_reset();
        bus.period = 16'd10;
        bus.enable = 1'b1;
        expect_at(19, K_OVR, 0, "t6_ovr");
        expect_at(20, K_OVR, 1, "t6_set");
        expect_at(24, K_OVR, 1, "t6_sticky");
        expect_at(25, K_OVR, 0, "t6_clr");
        expect_at(29, K_OVR, 0, "t6_clr");
        expect_at(30, K_OVR, 1, "t6_setwin");
        expect_at(30, K_MISS, 2, "t6_miss");
        while (cyc < 31) begin
            bus.ovr_clr = (cyc + 1 == 25) || (cyc + 1 == 30);
            step();
        end
        bus.ovr_clr = 1'b0;
        flush_sb();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
